// File: rtl/risky_pkg.sv
// rtl/risky_pkg.sv - shared types for the unified-memory arbiter
package risky_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT_GNT,
        ARB_WAIT_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IFETCH,
        OWN_DATA
    } arb_owner_t;

endpackage

// File: rtl/arb_priority.sv
// rtl/arb_priority.sv - data-priority winner selection with fetch anti-starvation
// Ports:
//   if_req, d_req  - pending fetch / data requests
//   starve_cnt     - consecutive data wins while fetch was waiting
//   winner         - selected owner (meaningful only when a request is present)
//   starve_nxt     - counter value to register if this arbitration is taken
module arb_priority
    import risky_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output arb_owner_t       winner,
    output logic [CNT_W-1:0] starve_nxt
);

    logic fetch_starved;

    assign fetch_starved = if_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

    always_comb begin
        winner     = OWN_IFETCH;
        starve_nxt = '0;
        if (d_req && !fetch_starved) begin
            winner = OWN_DATA;
            // Data only wins a contest below the limit, so the increment
            // saturates at STARVE_LIMIT by construction.
            if (if_req) begin
                starve_nxt = starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a single-ported unified memory
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   if_*                         - fetch read port (req/addr in, gnt/rvalid/rdata out, flush in)
//   d_*                          - data port (req/we/addr/wdata/be in, gnt/rvalid/rdata out)
//   mem_*                        - memory req/gnt/rvalid interface, one outstanding transaction
//   busy_o                       - a transaction is in progress
module mem_arbiter
    import risky_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                if_flush_i,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t       state, state_nxt;
    arb_owner_t       owner, winner;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic             discard;
    logic             launch;
    logic             gnt_hit;
    logic             resp_hit;

    arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_priority (
        .if_req     (if_req_i),
        .d_req      (d_req_i),
        .starve_cnt (starve_cnt),
        .winner     (winner),
        .starve_nxt (starve_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (if_req_i || d_req_i) begin
                    launch    = 1'b1;
                    state_nxt = ARB_WAIT_GNT;
                end
            end
            ARB_WAIT_GNT: begin
                if (mem_gnt_i) begin
                    state_nxt = ARB_WAIT_RESP;
                end
            end
            ARB_WAIT_RESP: begin
                if (mem_rvalid_i) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Handshake qualifiers: memory strobes outside their state are ignored.
    assign gnt_hit  = (state == ARB_WAIT_GNT)  && mem_gnt_i;
    assign resp_hit = (state == ARB_WAIT_RESP) && mem_rvalid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= OWN_IFETCH;
            starve_cnt  <= '0;
            discard     <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
        end else begin
            if (launch) begin
                owner      <= winner;
                starve_cnt <= starve_nxt;
                mem_req_o  <= 1'b1;
                if (winner == OWN_DATA) begin
                    mem_we_o    <= d_we_i;
                    mem_addr_o  <= d_addr_i;
                    mem_wdata_o <= d_wdata_i;
                    mem_be_o    <= d_be_i;
                end else begin
                    mem_we_o    <= 1'b0;
                    mem_addr_o  <= if_addr_i;
                    mem_wdata_o <= '0;
                    mem_be_o    <= '1;
                end
            end else if (gnt_hit) begin
                mem_req_o <= 1'b0;
            end

            // The response still has to be consumed, so a flushed fetch keeps
            // the transaction alive and only masks its rvalid.
            if (resp_hit) begin
                discard <= 1'b0;
            end else if (if_flush_i && (owner == OWN_IFETCH) && (state != ARB_IDLE)) begin
                discard <= 1'b1;
            end
        end
    end

    assign if_gnt_o    = gnt_hit && (owner == OWN_IFETCH);
    assign d_gnt_o     = gnt_hit && (owner == OWN_DATA);
    assign if_rvalid_o = resp_hit && (owner == OWN_IFETCH) && !discard && !if_flush_i;
    assign d_rvalid_o  = resp_hit && (owner == OWN_DATA);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;
    assign busy_o      = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import risky_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        if_flush_i;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    int n_cmp;
    int n_err;

    mem_arbiter #(
        .STARVE_LIMIT (4),
        .ADDR_W       (32),
        .DATA_W       (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .if_flush_i   (if_flush_i),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_be_i       (d_be_i),
        .d_gnt_o      (d_gnt_o),
        .d_rvalid_o   (d_rvalid_o),
        .d_rdata_o    (d_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_if_gnt"},    if_gnt_o,    0);
        chk({tag, "_if_rvalid"}, if_rvalid_o, 0);
        chk({tag, "_if_rdata"},  if_rdata_o,  0);
        chk({tag, "_d_gnt"},     d_gnt_o,     0);
        chk({tag, "_d_rvalid"},  d_rvalid_o,  0);
        chk({tag, "_d_rdata"},   d_rdata_o,   0);
        chk({tag, "_mem_req"},   mem_req_o,   0);
        chk({tag, "_mem_we"},    mem_we_o,    0);
        chk({tag, "_mem_addr"},  mem_addr_o,  0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
        chk({tag, "_mem_be"},    mem_be_o,    0);
        chk({tag, "_busy"},      busy_o,      0);
        chk({tag, "_state"},     dut.state,   ARB_IDLE);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        if_flush_i   = 1'b0;
        d_req_i      = 1'b0;
        d_we_i       = 1'b0;
        d_addr_i     = '0;
        d_wdata_i    = '0;
        d_be_i       = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;

        // Reset state
        tick();
        tick();
        chk_outputs_zero("reset");
        chk("reset_starve", dut.starve_cnt, 0);
        chk("reset_owner", dut.owner, OWN_IFETCH);
        rst = 1'b0;

        // Single fetch to 0x100, gnt immediately, rvalid two cycles after gnt
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        settle();
        chk("t1_req_not_yet", mem_req_o, 0);
        tick();
        chk("t1_mem_req", mem_req_o, 1);
        chk("t1_mem_addr", mem_addr_o, 32'h100);
        chk("t1_mem_be", mem_be_o, 4'hF);
        chk("t1_mem_we", mem_we_o, 0);
        chk("t1_busy", busy_o, 1);
        mem_gnt_i = 1'b1;
        settle();
        chk("t1_if_gnt", if_gnt_o, 1);
        chk("t1_d_gnt", d_gnt_o, 0);
        tick();
        if_req_i  = 1'b0;
        mem_gnt_i = 1'b0;
        settle();
        chk("t1_req_dropped", mem_req_o, 0);
        chk("t1_no_early_rvalid", if_rvalid_o, 0);
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEADBEEF;
        settle();
        chk("t1_if_rvalid", if_rvalid_o, 1);
        chk("t1_if_rdata", if_rdata_o, 32'hDEADBEEF);
        chk("t1_d_rvalid", d_rvalid_o, 0);
        chk("t1_d_rdata", d_rdata_o, 0);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk("t1_idle", busy_o, 0);
        chk("t1_rdata_cleared", if_rdata_o, 0);

        // Both requesters held: four data wins, then fetch
        if_req_i  = 1'b1;
        if_addr_i = 32'h200;
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h300;
        d_wdata_i = 32'h55AA55AA;
        d_be_i    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            logic is_d;
            is_d = (i < 4);
            tick();
            chk($sformatf("t2_req_%0d", i), mem_req_o, 1);
            chk($sformatf("t2_we_%0d", i), mem_we_o, is_d);
            chk($sformatf("t2_addr_%0d", i), mem_addr_o, is_d ? 32'h300 : 32'h200);
            chk($sformatf("t2_wdata_%0d", i), mem_wdata_o, is_d ? 32'h55AA55AA : 32'h0);
            chk($sformatf("t2_be_%0d", i), mem_be_o, 4'hF);
            chk($sformatf("t2_starve_%0d", i), dut.starve_cnt, is_d ? (i + 1) : 0);
            mem_gnt_i = 1'b1;
            settle();
            chk($sformatf("t2_d_gnt_%0d", i), d_gnt_o, is_d);
            chk($sformatf("t2_if_gnt_%0d", i), if_gnt_o, !is_d);
            tick();
            mem_gnt_i = 1'b0;
            if (!is_d) begin
                if_req_i = 1'b0;
                d_req_i  = 1'b0;
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hA0 + i;
            settle();
            chk($sformatf("t2_d_rvalid_%0d", i), d_rvalid_o, is_d);
            chk($sformatf("t2_if_rvalid_%0d", i), if_rvalid_o, !is_d);
            chk($sformatf("t2_if_rdata_%0d", i), if_rdata_o, is_d ? 32'h0 : (32'hA0 + i));
            tick();
            mem_rvalid_i = 1'b0;
        end
        d_we_i = 1'b0;

        // Data read stalled three cycles by memory
        d_req_i  = 1'b1;
        d_addr_i = 32'h500;
        d_be_i   = 4'h3;
        tick();
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("t3_req_%0d", k), mem_req_o, 1);
            chk($sformatf("t3_addr_%0d", k), mem_addr_o, 32'h500);
            chk($sformatf("t3_no_gnt_%0d", k), d_gnt_o, 0);
            tick();
        end
        mem_gnt_i = 1'b1;
        settle();
        chk("t3_req_still", mem_req_o, 1);
        chk("t3_d_gnt", d_gnt_o, 1);
        chk("t3_be", mem_be_o, 4'h3);
        tick();
        d_req_i      = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFEF00D;
        settle();
        chk("t3_d_rvalid", d_rvalid_o, 1);
        chk("t3_d_rdata", d_rdata_o, 32'hCAFEF00D);
        chk("t3_if_rvalid", if_rvalid_o, 0);
        tick();
        mem_rvalid_i = 1'b0;

        // Flush during WAIT_RESP of a fetch to 0x400
        if_req_i  = 1'b1;
        if_addr_i = 32'h400;
        tick();
        chk("t4_addr", mem_addr_o, 32'h400);
        mem_gnt_i = 1'b1;
        tick();
        if_req_i   = 1'b0;
        mem_gnt_i  = 1'b0;
        if_flush_i = 1'b1;
        settle();
        tick();
        if_flush_i   = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h12345678;
        settle();
        chk("t4_discard", dut.discard, 1);
        chk("t4_if_rvalid", if_rvalid_o, 0);
        chk("t4_if_rdata", if_rdata_o, 0);
        chk("t4_busy", busy_o, 1);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk("t4_idle", busy_o, 0);
        chk("t4_discard_clr", dut.discard, 0);
        d_req_i  = 1'b1;
        d_addr_i = 32'h600;
        d_be_i   = 4'hF;
        tick();
        chk("t4_d_addr", mem_addr_o, 32'h600);
        mem_gnt_i = 1'b1;
        settle();
        chk("t4_d_gnt", d_gnt_o, 1);
        tick();
        d_req_i      = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000600D;
        settle();
        chk("t4_d_rvalid", d_rvalid_o, 1);
        chk("t4_d_rdata", d_rdata_o, 32'h0000600D);
        tick();
        mem_rvalid_i = 1'b0;

        // Flush coincident with the fetch response
        if_req_i  = 1'b1;
        if_addr_i = 32'h440;
        tick();
        mem_gnt_i = 1'b1;
        tick();
        if_req_i     = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        if_flush_i   = 1'b1;
        mem_rdata_i  = 32'h77;
        settle();
        chk("t4b_if_rvalid", if_rvalid_o, 0);
        tick();
        mem_rvalid_i = 1'b0;
        if_flush_i   = 1'b0;

        // Reset during WAIT_RESP, then a normal fetch
        if_req_i  = 1'b1;
        if_addr_i = 32'h480;
        tick();
        mem_gnt_i = 1'b1;
        tick();
        if_req_i  = 1'b0;
        mem_gnt_i = 1'b0;
        settle();
        chk("t5_busy_before", busy_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk_outputs_zero("t5_rst");
        if_req_i  = 1'b1;
        if_addr_i = 32'h700;
        tick();
        chk("t5_req", mem_req_o, 1);
        chk("t5_addr", mem_addr_o, 32'h700);
        mem_gnt_i = 1'b1;
        settle();
        chk("t5_if_gnt", if_gnt_o, 1);
        tick();
        if_req_i     = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0BADF00D;
        settle();
        chk("t5_if_rvalid", if_rvalid_o, 1);
        chk("t5_if_rdata", if_rdata_o, 32'h0BADF00D);
        tick();
        mem_rvalid_i = 1'b0;

        // Three back-to-back data writes: one transaction per three cycles
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h800;
        d_wdata_i = 32'h1;
        d_be_i    = 4'hF;
        for (int c = 0; c < 9; c++) begin
            tick();
            case (c % 3)
                0: begin
                    chk($sformatf("t6_req_hi_%0d", c), mem_req_o, 1);
                    chk($sformatf("t6_starve_%0d", c), dut.starve_cnt, 0);
                    mem_gnt_i = 1'b1;
                    settle();
                    chk($sformatf("t6_d_gnt_%0d", c), d_gnt_o, 1);
                end
                1: begin
                    chk($sformatf("t6_req_lo_%0d", c), mem_req_o, 0);
                    mem_gnt_i    = 1'b0;
                    mem_rvalid_i = 1'b1;
                    settle();
                    chk($sformatf("t6_ack_%0d", c), d_rvalid_o, 1);
                end
                default: begin
                    chk($sformatf("t6_idle_%0d", c), mem_req_o, 0);
                    mem_rvalid_i = 1'b0;
                    if (c == 8) d_req_i = 1'b0;
                end
            endcase
        end
        tick();
        settle();
        chk("t6_done_idle", busy_o, 0);
        chk("t6_done_req", mem_req_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
